// File: rtl/cont_cres_2dig_pkg.sv
// +--------------------------------------------------------------------+
// | cont_cres_2dig_pkg : BCD digit type, limits and helpers (rev 1.0)    |
// +--------------------------------------------------------------------+
`default_nettype none

package cont_cres_2dig_pkg;

  localparam int unsigned BCD_MAX = 9;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t clamp_bcd(input bcd_t d);
    return (d > bcd_t'(BCD_MAX)) ? bcd_t'(BCD_MAX) : d;
  endfunction

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == bcd_t'(BCD_MAX)) ? bcd_t'(0) : d + bcd_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cont_cres_2dig_cres.sv
// +--------------------------------------------------------------------+
// | cont_cres : one up-counting BCD decade with clear/load (rev 1.0)     |
// +--------------------------------------------------------------------+
`default_nettype none

module cont_cres
  import cont_cres_2dig_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  input  logic ld_i,
  input  bcd_t d_i,
  output bcd_t q_o,
  output logic co_o
);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (ld_i) begin
      q_d = clamp_bcd(d_i);
    end else if (en_i) begin
      q_d = bcd_inc(q_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o  = q_q;
  assign co_o = en_i & (q_q == bcd_t'(BCD_MAX));

endmodule

`default_nettype wire

// File: rtl/cont_cres_2dig.sv
// +--------------------------------------------------------------------+
// | cont_cres_2dig : two-digit BCD counter with limit, wrap/hold (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module cont_cres_2dig
  import cont_cres_2dig_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  input  logic ld_i,
  input  bcd_t d1_i,
  input  bcd_t d0_i,
  input  bcd_t lim1_i,
  input  bcd_t lim0_i,
  output bcd_t q1_o,
  output bcd_t q0_o,
  output logic tc_o,
  output logic done_o
);

  logic [7:0] w_lim_eff;
  logic [7:0] w_q;
  logic [7:0] w_inc;
  logic       w_at_lim;
  logic       w_wrap_clr;
  logic       w_dig_clr;
  logic       w_unit_en;
  logic       w_unit_co;
  logic       w_tens_co;
  logic       done_q;
  logic       done_d;

  assign w_lim_eff = {clamp_bcd(lim1_i), clamp_bcd(lim0_i)};
  assign w_q       = {q1_o, q0_o};
  assign w_at_lim  = (w_q == w_lim_eff);

  // Value the pair would take after a plain increment, used to spot arrival.
  assign w_inc[3:0] = bcd_inc(q0_o);
  assign w_inc[7:4] = (q0_o == bcd_t'(BCD_MAX)) ? bcd_inc(q1_o) : q1_o;

  // At the limit the units never count: either both digits clear (wrap) or hold.
  assign w_wrap_clr = en_i & w_at_lim & WRAP & ~ld_i;
  assign w_dig_clr  = clr_i | w_wrap_clr;
  assign w_unit_en  = en_i & ~w_at_lim;

  cont_cres u_units (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_unit_en),
    .clr_i  (w_dig_clr),
    .ld_i   (ld_i),
    .d_i    (d0_i),
    .q_o    (q0_o),
    .co_o   (w_unit_co)
  );

  cont_cres u_tens (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_unit_co),
    .clr_i  (w_dig_clr),
    .ld_i   (ld_i),
    .d_i    (d1_i),
    .q_o    (q1_o),
    .co_o   (w_tens_co)
  );

  // Wrapping out of the limit is not an arrival, so it never pulses Done.
  always_comb begin
    done_d = en_i & ~clr_i & ~ld_i & ~w_at_lim & (w_inc == w_lim_eff);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign tc_o   = w_at_lim;
  assign done_o = done_q;

  logic w_unused;
  assign w_unused = w_tens_co;

endmodule

`default_nettype wire

// File: tb/tb_cont_cres_2dig.sv
// +--------------------------------------------------------------------+
// | tb_cont_cres_2dig : scoreboard bench for both WRAP settings (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cont_cres_2dig;

  logic       clk;
  logic       rst_n;
  logic       en, clr, ld;
  logic [3:0] d1, d0, lim1, lim0;
  logic [3:0] qa1, qa0, qb1, qb0;
  logic       tca, tcb, donea, doneb;

  typedef struct {
    bit         sel;
    logic [7:0] q;
    logic       tc;
    logic       done;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   next_id = 0;

  cont_cres_2dig #(.WRAP(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .ld_i(ld),
    .d1_i(d1), .d0_i(d0), .lim1_i(lim1), .lim0_i(lim0),
    .q1_o(qa1), .q0_o(qa0), .tc_o(tca), .done_o(donea)
  );

  cont_cres_2dig #(.WRAP(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .ld_i(ld),
    .d1_i(d1), .d0_i(d0), .lim1_i(lim1), .lim0_i(lim0),
    .q1_o(qb1), .q0_o(qb0), .tc_o(tcb), .done_o(doneb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] clampb(input logic [3:0] x);
    return (x > 4'd9) ? 4'd9 : x;
  endfunction

  function automatic logic [7:0] bcd(input int k);
    return 8'(((k / 10) * 16) + (k % 10));
  endfunction

  task automatic push(input bit sel, input logic [7:0] q, input logic done);
    exp_t e;
    e.sel  = sel;
    e.q    = q;
    e.tc   = (q == {clampb(lim1), clampb(lim0)});
    e.done = done;
    e.id   = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic step(input logic s_en, input logic s_clr, input logic s_ld,
                      input logic [7:0] d, input logic [7:0] qa, input logic da,
                      input bit chk_b = 1'b0, input logic [7:0] qb = 8'h00,
                      input logic db = 1'b0);
    en = s_en; clr = s_clr; ld = s_ld; d1 = d[7:4]; d0 = d[3:0];
    @(posedge clk);
    #1;
    push(1'b0, qa, da);
    if (chk_b) push(1'b1, qb, db);
    @(negedge clk);
    #1;
  endtask

  // Monitor: outputs are stable at the falling edge; drain everything queued.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [9:0] act, req;
      e   = sb.pop_front();
      act = e.sel ? {qb1, qb0, tcb, doneb} : {qa1, qa0, tca, donea};
      req = {e.q, e.tc, e.done};
      n_cmp++;
      if (act !== req) begin
        n_err++;
        $display("FAIL chk%0d dut_%s: got q=%h tc=%b done=%b, want q=%h tc=%b done=%b",
                 e.id, e.sel ? "hold" : "wrap", act[9:2], act[1], act[0],
                 req[9:2], req[1], req[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; ld = 1'b0;
    d1 = 4'd0; d0 = 4'd0; lim1 = 4'd2; lim0 = 4'd3;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push(1'b0, 8'h00, 1'b0);
    push(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Limit 23, wrap: count up through the carry, pulse at 23, then back to 00
    for (int k = 1; k <= 23; k++) step(1, 0, 0, 8'h00, bcd(k), k == 23);
    step(1, 0, 0, 8'h00, 8'h00, 0);

    // Idle after arrival: Q holds, Done clears
    step(0, 0, 1, 8'h22, 8'h22, 0);
    step(1, 0, 0, 8'h00, 8'h23, 1);
    step(0, 0, 0, 8'h00, 8'h23, 0);

    // Asynchronous reset mid-count at 47
    step(0, 0, 1, 8'h47, 8'h47, 0);
    en = 1'b0; ld = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push(1'b0, 8'h00, 1'b0);
    push(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) step(1, 0, 0, 8'h00, bcd(k), 0);

    // Load above limit: 95 -> 99 -> 00 -> 50, one pulse at 50
    lim1 = 4'd5; lim0 = 4'd0;
    step(0, 0, 1, 8'h95, 8'h95, 0);
    for (int k = 96; k <= 150; k++) step(1, 0, 0, 8'h00, bcd(k % 100), k == 150);

    // Priority: Clr beats Ld and En; Ld beats En and clamps the tens digit
    step(0, 0, 1, 8'h30, 8'h30, 0);
    step(1, 1, 1, 8'h30, 8'h00, 0);
    step(1, 0, 1, 8'hC7, 8'h97, 0);

    // Limit F:F behaves as 99
    lim1 = 4'hF; lim0 = 4'hF;
    step(1, 0, 0, 8'h00, 8'h98, 0);
    step(1, 0, 0, 8'h00, 8'h99, 1);
    step(1, 0, 0, 8'h00, 8'h00, 0);

    // Limit 05: wrap instance cycles, hold instance parks at 05
    lim1 = 4'd0; lim0 = 4'd5;
    step(0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 0);
    for (int k = 1; k <= 10; k++)
      step(1, 0, 0, 8'h00, (k <= 5) ? bcd(k) : bcd(k - 6), k == 5,
           1, bcd((k < 5) ? k : 5), k == 5);

    // Limit 00 with wrap: stuck at 00, pulse only on 99 -> 00
    lim1 = 4'd0; lim0 = 4'd0;
    step(0, 1, 0, 8'h00, 8'h00, 0);
    step(1, 0, 0, 8'h00, 8'h00, 0);
    step(0, 0, 1, 8'h98, 8'h98, 0);
    step(1, 0, 0, 8'h00, 8'h99, 0);
    step(1, 0, 0, 8'h00, 8'h00, 1);
    step(1, 0, 0, 8'h00, 8'h00, 0);

    en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
